// File: rtl/program_sequencer.sv
// Fetch/issue controller for the 1-bit processor: owns the PC and return stack,
// reads the program ROM one instruction at a time, and lends the ROM write port to the loader.
module program_sequencer #(
   parameter int ADDR_W      = 8,
   parameter int WORD        = 8,
   parameter int STACK_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   output logic              rom_read,
   output logic              rom_write,
   output logic [ADDR_W-1:0] rom_address,
   output logic [WORD-1:0]   rom_data_in,
   input  logic [WORD-1:0]   rom_data_out,
   output logic              instr_valid,
   output logic [WORD-1:0]   instr,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              instr_ready,
   input  logic              jmp,
   input  logic [ADDR_W-1:0] jmp_target,
   input  logic              rtn,
   input  logic              skip,
   input  logic              halt,
   input  logic              load_valid,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [WORD-1:0]   load_data,
   output logic              load_ready,
   output logic              err_ovf,
   output logic              err_unf
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_FETCH  = 2'd1;
   localparam logic [1:0] S_ISSUE  = 2'd2;
   localparam logic [1:0] S_HALTED = 2'd3;

   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [1:0]        state;
   logic [ADDR_W-1:0] pc;
   logic [SP_W-1:0]   sp;
   logic [ADDR_W-1:0] stack [STACK_DEPTH];

   logic              loader_phase;
   logic              accept;
   logic              stack_full;
   logic              stack_empty;
   logic              do_push;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] stack_top;

   assign rom_data_in = load_data;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      loader_phase = (state == S_IDLE) || (state == S_HALTED);
      load_ready   = loader_phase && load_valid;
      rom_write    = load_ready;
      rom_read     = (state == S_FETCH);
      rom_address  = rom_write ? load_addr : pc;
      instr_valid  = (state == S_ISSUE);
      accept       = instr_valid && instr_ready;
      stack_full   = (sp == SP_W'(STACK_DEPTH));
      stack_empty  = (sp == '0);
      pc_inc       = pc + ADDR_W'(1);
      do_push      = accept && !halt && jmp && !stack_full;
      stack_top    = stack[IDX_W'(sp - SP_W'(1))];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         pc       <= RESET_PC;
         sp       <= '0;
         instr    <= '0;
         instr_pc <= '0;
         err_ovf  <= 1'b0;
         err_unf  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               // The loader owns the ROM port while it is requesting, even with run=1.
               if (run && !load_valid) state <= S_FETCH;
            end
            S_FETCH: begin
               instr    <= rom_data_out;
               instr_pc <= pc;
               state    <= S_ISSUE;
            end
            S_ISSUE: begin
               if (accept) begin
                  if (halt) begin
                     state <= S_HALTED;
                  end else begin
                     if (jmp) begin
                        pc <= jmp_target;
                        if (stack_full) err_ovf <= 1'b1;
                        else            sp      <= sp + SP_W'(1);
                     end else if (rtn) begin
                        if (stack_empty) begin
                           err_unf <= 1'b1;
                           pc      <= pc_inc;
                        end else begin
                           pc <= stack_top;
                           sp <= sp - SP_W'(1);
                        end
                     end else if (skip) begin
                        pc <= pc + ADDR_W'(2);
                     end else begin
                        pc <= pc_inc;
                     end
                     state <= run ? S_FETCH : S_IDLE;
                  end
               end
            end
            S_HALTED: state <= S_HALTED;
            default:  state <= S_IDLE;
         endcase
      end
   end

   // NOTE: stack storage has no reset; sp=0 after reset makes every entry unreachable until rewritten.
   always_ff @(posedge clk) begin
      if (do_push) stack[IDX_W'(sp)] <= pc_inc;
   end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: loader, sequential fetch, call/return stack,
// PC wrap, stall, halt and reset, all against a small behavioural ROM.
module tb_program_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       run;
   logic       rom_read;
   logic       rom_write;
   logic [7:0] rom_address;
   logic [7:0] rom_data_in;
   logic [7:0] rom_data_out;
   logic       instr_valid;
   logic [7:0] instr;
   logic [7:0] instr_pc;
   logic       instr_ready;
   logic       jmp;
   logic [7:0] jmp_target;
   logic       rtn;
   logic       skip;
   logic       halt;
   logic       load_valid;
   logic [7:0] load_addr;
   logic [7:0] load_data;
   logic       load_ready;
   logic       err_ovf;
   logic       err_unf;

   int n_eval = 0;
   int n_fail = 0;
   int n_load_pulses = 0;

   // ROM model: unwritten words read back as address ^ 8'h5A.
   logic [7:0] rom [256];
   bit         written [256];

   always #5 clk = ~clk;

   program_sequencer dut (
      .clk(clk), .rst_n(rst_n), .run(run),
      .rom_read(rom_read), .rom_write(rom_write), .rom_address(rom_address),
      .rom_data_in(rom_data_in), .rom_data_out(rom_data_out),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .instr_ready(instr_ready), .jmp(jmp), .jmp_target(jmp_target),
      .rtn(rtn), .skip(skip), .halt(halt),
      .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
      .load_ready(load_ready), .err_ovf(err_ovf), .err_unf(err_unf)
   );

   function automatic logic [7:0] rom_val(input logic [7:0] a);
      return written[a] ? rom[a] : (a ^ 8'h5A);
   endfunction

   assign rom_data_out = rom_val(rom_address);

   always @(posedge clk) begin
      if (rom_write) begin
         rom[rom_address]     <= rom_data_in;
         written[rom_address] <= 1'b1;
      end
   end

   always @(posedge clk) if (load_ready) n_load_pulses <= n_load_pulses + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_eval++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One FETCH cycle then one ISSUE cycle; control pulses are dropped after the accept edge.
   task automatic fetch_issue(input logic [7:0] exp_pc);
      step();
      jmp  = 1'b0;
      rtn  = 1'b0;
      skip = 1'b0;
      check("fetch_read",  32'(rom_read),    32'd1);
      check("fetch_valid", 32'(instr_valid), 32'd0);
      check("fetch_addr",  32'(rom_address), 32'(exp_pc));
      step();
      check("issue_valid", 32'(instr_valid), 32'd1);
      check("issue_read",  32'(rom_read),    32'd0);
      check("issue_pc",    32'(instr_pc),    32'(exp_pc));
      check("issue_instr", 32'(instr),       32'(rom_val(exp_pc)));
   endtask

   initial begin
      logic [7:0] load_words [3];
      load_words[0] = 8'h1A;
      load_words[1] = 8'h2B;
      load_words[2] = 8'h3C;

      rst_n = 1'b0; run = 1'b0; instr_ready = 1'b0;
      jmp = 1'b0; jmp_target = '0; rtn = 1'b0; skip = 1'b0; halt = 1'b0;
      load_valid = 1'b0; load_addr = '0; load_data = '0;

      #3;
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", 32'(instr),       32'd0);
      check("rst_pc",    32'(instr_pc),    32'd0);
      check("rst_ovf",   32'(err_ovf),     32'd0);
      check("rst_unf",   32'(err_unf),     32'd0);
      check("rst_read",  32'(rom_read),    32'd0);
      check("rst_write", 32'(rom_write),   32'd0);
      step();
      rst_n = 1'b1;

      // Loader writes in IDLE
      for (int i = 0; i < 3; i++) begin
         load_valid = 1'b1;
         load_addr  = 8'(i);
         load_data  = load_words[i];
         #1;
         check("load_ready", 32'(load_ready),  32'd1);
         check("load_write", 32'(rom_write),   32'd1);
         check("load_addr",  32'(rom_address), 32'(i));
         check("load_read",  32'(rom_read),    32'd0);
         step();
      end
      load_valid = 1'b0;
      check("load_pulses", 32'(n_load_pulses), 32'd3);
      check("load_word0",  32'(rom_val(8'h00)), 32'h1A);

      // Sequential execution
      run = 1'b1;
      instr_ready = 1'b1;
      for (int k = 0; k < 6; k++) fetch_issue(8'(k));

      // Call from 5 to 0x40 and return to 6
      jmp = 1'b1; jmp_target = 8'h40;
      fetch_issue(8'h40);
      rtn = 1'b1;
      fetch_issue(8'h06);

      // Five nested calls overflow a 4-deep stack, the fifth jump still taken
      jmp = 1'b1; jmp_target = 8'h10; fetch_issue(8'h10);
      jmp = 1'b1; jmp_target = 8'h20; fetch_issue(8'h20);
      jmp = 1'b1; jmp_target = 8'h30; fetch_issue(8'h30);
      jmp = 1'b1; jmp_target = 8'h40; fetch_issue(8'h40);
      check("ovf_before", 32'(err_ovf), 32'd0);
      jmp = 1'b1; jmp_target = 8'h50; fetch_issue(8'h50);
      check("ovf_after",  32'(err_ovf), 32'd1);

      // Unwind: four returns, then one on an empty stack
      rtn = 1'b1; fetch_issue(8'h31);
      rtn = 1'b1; fetch_issue(8'h21);
      rtn = 1'b1; fetch_issue(8'h11);
      rtn = 1'b1; fetch_issue(8'h07);
      check("unf_before", 32'(err_unf), 32'd0);
      rtn = 1'b1; fetch_issue(8'h08);
      check("unf_after",  32'(err_unf), 32'd1);

      // PC wrap: skip from 0xFF lands on 0x01, sequential from 0xFF on 0x00
      jmp = 1'b1; jmp_target = 8'hFF; fetch_issue(8'hFF);
      skip = 1'b1; fetch_issue(8'h01);
      jmp = 1'b1; jmp_target = 8'hFF; fetch_issue(8'hFF);
      fetch_issue(8'h00);
      check("ovf_sticky", 32'(err_ovf), 32'd1);

      // Stall in ISSUE; loader must be refused during execution
      instr_ready = 1'b0;
      load_valid = 1'b1; load_addr = 8'h07; load_data = 8'h99;
      for (int c = 0; c < 3; c++) begin
         step();
         check("stall_valid", 32'(instr_valid), 32'd1);
         check("stall_pc",    32'(instr_pc),    32'd0);
         check("stall_instr", 32'(instr),       32'(rom_val(8'h00)));
         check("stall_read",  32'(rom_read),    32'd0);
         check("stall_lready",32'(load_ready),  32'd0);
         check("stall_write", 32'(rom_write),   32'd0);
      end
      load_valid = 1'b0;

      // Halt: run ignored, loader serviced
      instr_ready = 1'b1; halt = 1'b1;
      step();
      halt = 1'b0;
      check("halt_valid", 32'(instr_valid), 32'd0);
      check("halt_read",  32'(rom_read),    32'd0);
      step();
      step();
      check("halt_stay_read",  32'(rom_read),    32'd0);
      check("halt_stay_valid", 32'(instr_valid), 32'd0);
      load_valid = 1'b1; load_addr = 8'h07; load_data = 8'h99;
      #1;
      check("halt_lready", 32'(load_ready),  32'd1);
      check("halt_write",  32'(rom_write),   32'd1);
      check("halt_addr",   32'(rom_address), 32'h07);
      step();
      load_valid = 1'b0;
      check("halt_stored", 32'(rom_val(8'h07)), 32'h99);
      check("halt_after_read", 32'(rom_read), 32'd0);

      // Asynchronous reset out of HALTED
      #2;
      rst_n = 1'b0;
      #1;
      check("rst2_pc",    32'(instr_pc),    32'd0);
      check("rst2_instr", 32'(instr),       32'd0);
      check("rst2_ovf",   32'(err_ovf),     32'd0);
      check("rst2_unf",   32'(err_unf),     32'd0);
      check("rst2_valid", 32'(instr_valid), 32'd0);
      step();
      rst_n = 1'b1;
      fetch_issue(8'h00);

      // run dropped during ISSUE: instruction completes, then parks in IDLE
      run = 1'b0;
      step();
      check("stop_valid", 32'(instr_valid), 32'd0);
      check("stop_read",  32'(rom_read),    32'd0);
      step();
      check("stop_idle_read", 32'(rom_read), 32'd0);
      run = 1'b1;
      fetch_issue(8'h01);
      check("stop_unf", 32'(err_unf), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
      $finish;
   end

endmodule
